rr_arbiter8: RTL and testbench

Round-robin arbiter for eight requesters. It drives the 3-bit select of the downstream 8:1 channel multiplexer, so exactly one source's data reaches the shared output at a time. The grant is registered and held until the owner finishes, drops its request, or exceeds a configurable hold limit. Priority then rotates to the next index.

---
 rtl/rr_arbiter8_pkg.sv | 22 ++
 rtl/rr_arbiter8_pick.sv | 38 +++
 rtl/rr_arbiter8.sv | 124 ++++++++++++
 tb/tb_rr_arbiter8.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/rr_arbiter8_pkg.sv
// ============================================================================
// rr_arbiter8_pkg : shared state encoding and widths for rr_arbiter8  (rev 1.0)
// ============================================================================
`default_nettype none

package rr_arbiter8_pkg;

  localparam int N    = 8;
  localparam int SELW = 3;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  function automatic logic [N-1:0] onehot(input logic [SELW-1:0] idx);
    return N'(1) << idx;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arbiter8_pick.sv
// ============================================================================
// rr_pick : round-robin search from ptr upward with wrap  (rev 1.0)
// ============================================================================
`default_nettype none

module rr_pick
  import rr_arbiter8_pkg::*;
(
  input  logic [N-1:0]    req,
  input  logic [SELW-1:0] ptr,
  output logic            found,
  output logic [SELW-1:0] idx
);

  logic [2*N-1:0]  dbl;
  logic [N-1:0]    rot;
  logic [SELW-1:0] off;

  // Doubling the vector turns the rotate into a plain variable slice.
  assign dbl = {req, req};
  assign rot = dbl[ptr +: N];

  always_comb begin
    found = 1'b0;
    off   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (rot[i]) begin
        found = 1'b1;
        off   = SELW'(i);
      end
    end
  end

  assign idx = off + ptr;

endmodule

`default_nettype wire

// File: rtl/rr_arbiter8.sv
// ============================================================================
// rr_arbiter8 : 8-way round-robin arbiter with registered grant and hold limit (rev 1.0)
// ============================================================================
`default_nettype none

module rr_arbiter8 #(
  parameter int N        = rr_arbiter8_pkg::N,
  parameter int SELW     = rr_arbiter8_pkg::SELW,
  parameter int MAX_HOLD = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req,
  input  logic            done,
  output logic [N-1:0]    gnt,
  output logic [SELW-1:0] gnt_idx,
  output logic            gnt_valid
);

  import rr_arbiter8_pkg::state_t;
  import rr_arbiter8_pkg::IDLE;
  import rr_arbiter8_pkg::BUSY;
  import rr_arbiter8_pkg::onehot;

  localparam int            CW       = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
  localparam logic [CW-1:0] HOLD_LIM = CW'(MAX_HOLD);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  state_t          state, state_d;
  logic [SELW-1:0] ptr, ptr_d;
  logic [CW-1:0]   cnt, cnt_d;
  logic [N-1:0]    gnt_d;
  logic [SELW-1:0] idx_d;
  logic            valid_d;

  logic            hold_hit;
  logic            release_now;
  logic [N-1:0]    pick_req;
  logic [SELW-1:0] pick_ptr;
  logic            found;
  logic [SELW-1:0] win;

  // On release the owner is masked and the search starts just past it.
  always_comb begin
    hold_hit    = (MAX_HOLD != 0) && (cnt == HOLD_LIM);
    release_now = (state == BUSY) && (done || !req[gnt_idx] || hold_hit);
    pick_ptr    = (state == BUSY) ? gnt_idx + SELW'(1) : ptr;
    pick_req    = (state == BUSY) ? (req & ~gnt) : req;
  end

  rr_pick u_pick (
    .req   (pick_req),
    .ptr   (pick_ptr),
    .found (found),
    .idx   (win)
  );

  always_comb begin
    state_d = state;
    ptr_d   = ptr;
    cnt_d   = cnt;
    gnt_d   = gnt;
    idx_d   = gnt_idx;
    valid_d = gnt_valid;
    case (state)
      IDLE: begin
        if (found) begin
          state_d = BUSY;
          gnt_d   = onehot(win);
          idx_d   = win;
          valid_d = 1'b1;
          cnt_d   = CNT_ONE;
        end
      end
      BUSY: begin
        if (release_now) begin
          ptr_d = pick_ptr;
          if (found) begin
            gnt_d   = onehot(win);
            idx_d   = win;
            valid_d = 1'b1;
            cnt_d   = CNT_ONE;
          end else begin
            state_d = IDLE;
            gnt_d   = '0;
            idx_d   = '0;
            valid_d = 1'b0;
            cnt_d   = '0;
          end
        end else if (cnt != HOLD_LIM) begin
          cnt_d = cnt + CNT_ONE;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
        idx_d   = '0;
        valid_d = 1'b0;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      ptr       <= '0;
      cnt       <= '0;
      gnt       <= '0;
      gnt_idx   <= '0;
      gnt_valid <= 1'b0;
    end else begin
      state     <= state_d;
      ptr       <= ptr_d;
      cnt       <= cnt_d;
      gnt       <= gnt_d;
      gnt_idx   <= idx_d;
      gnt_valid <= valid_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_rr_arbiter8.sv
// ============================================================================
// tb_rr_arbiter8 : scoreboard bench for rr_arbiter8 with a hold limit of 4 (rev 1.0)
// ============================================================================
`default_nettype none

module tb_rr_arbiter8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] req = 8'h00;
  logic       done = 1'b0;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_valid;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic       rs;
    logic [7:0] rq;
    logic       dn;
    logic       v;
    logic [2:0] ix;
  } row_t;

  typedef struct packed {
    logic       v;
    logic [2:0] ix;
  } exp_t;

  exp_t sb[$];

  rr_arbiter8 #(.MAX_HOLD(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .done      (done),
    .gnt       (gnt),
    .gnt_idx   (gnt_idx),
    .gnt_valid (gnt_valid)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic test_reset();
    row_t rows[$] = '{
      '{1'b1, 8'hFF, 1'b0, 1'b0, 3'd0},
      '{1'b1, 8'hFF, 1'b0, 1'b0, 3'd0},
      '{1'b0, 8'hFF, 1'b0, 1'b1, 3'd0},
      '{1'b0, 8'hFF, 1'b0, 1'b1, 3'd0}
    };
    exp_t e;
    logic [7:0] eg;
    foreach (rows[k]) begin
      @(negedge clk);
      rst = rows[k].rs; req = rows[k].rq; done = rows[k].dn;
      sb.push_back('{rows[k].v, rows[k].ix});
      @(posedge clk); #1;
      e = sb.pop_front();
      eg = e.v ? (8'b1 << e.ix) : 8'b0;
      checks++;
      if ({gnt_valid, gnt_idx, gnt} !== {e.v, e.ix, eg}) begin
        errors++;
        $display("FAIL reset[%0d]: got v=%0b idx=%0d gnt=%h, want v=%0b idx=%0d gnt=%h",
                 k, gnt_valid, gnt_idx, gnt, e.v, e.ix, eg);
      end
    end
  endtask

  task automatic test_rotation();
    row_t rows[$];
    exp_t e;
    logic [7:0] eg;
    rows.push_back('{1'b1, 8'hFF, 1'b0, 1'b0, 3'd0});
    rows.push_back('{1'b0, 8'hFF, 1'b0, 1'b1, 3'd0});
    for (int i = 1; i <= 8; i++) rows.push_back('{1'b0, 8'hFF, 1'b1, 1'b1, 3'(i % 8)});
    foreach (rows[k]) begin
      @(negedge clk);
      rst = rows[k].rs; req = rows[k].rq; done = rows[k].dn;
      sb.push_back('{rows[k].v, rows[k].ix});
      @(posedge clk); #1;
      e = sb.pop_front();
      eg = e.v ? (8'b1 << e.ix) : 8'b0;
      checks++;
      if ({gnt_valid, gnt_idx, gnt} !== {e.v, e.ix, eg}) begin
        errors++;
        $display("FAIL rotation[%0d]: got v=%0b idx=%0d gnt=%h, want v=%0b idx=%0d gnt=%h",
                 k, gnt_valid, gnt_idx, gnt, e.v, e.ix, eg);
      end
    end
  endtask

  task automatic test_sparse_wrap();
    row_t rows[$] = '{
      '{1'b1, 8'h84, 1'b0, 1'b0, 3'd0},
      '{1'b0, 8'h84, 1'b0, 1'b1, 3'd2},
      '{1'b0, 8'h84, 1'b1, 1'b1, 3'd7},
      '{1'b0, 8'h84, 1'b1, 1'b1, 3'd2},
      '{1'b0, 8'h84, 1'b1, 1'b1, 3'd7}
    };
    exp_t e;
    logic [7:0] eg;
    foreach (rows[k]) begin
      @(negedge clk);
      rst = rows[k].rs; req = rows[k].rq; done = rows[k].dn;
      sb.push_back('{rows[k].v, rows[k].ix});
      @(posedge clk); #1;
      e = sb.pop_front();
      eg = e.v ? (8'b1 << e.ix) : 8'b0;
      checks++;
      if ({gnt_valid, gnt_idx, gnt} !== {e.v, e.ix, eg}) begin
        errors++;
        $display("FAIL sparse_wrap[%0d]: got v=%0b idx=%0d gnt=%h, want v=%0b idx=%0d gnt=%h",
                 k, gnt_valid, gnt_idx, gnt, e.v, e.ix, eg);
      end
    end
  endtask

  // Two requesters alternate every 4 cycles; a lone requester sees a one-cycle gap.
  task automatic test_timeout();
    row_t rows[$];
    exp_t e;
    logic [7:0] eg;
    rows.push_back('{1'b1, 8'h03, 1'b0, 1'b0, 3'd0});
    for (int i = 0; i < 4; i++) rows.push_back('{1'b0, 8'h03, 1'b0, 1'b1, 3'd0});
    for (int i = 0; i < 4; i++) rows.push_back('{1'b0, 8'h03, 1'b0, 1'b1, 3'd1});
    rows.push_back('{1'b0, 8'h03, 1'b0, 1'b1, 3'd0});
    rows.push_back('{1'b1, 8'h01, 1'b0, 1'b0, 3'd0});
    for (int i = 0; i < 4; i++) rows.push_back('{1'b0, 8'h01, 1'b0, 1'b1, 3'd0});
    rows.push_back('{1'b0, 8'h01, 1'b0, 1'b0, 3'd0});
    rows.push_back('{1'b0, 8'h01, 1'b0, 1'b1, 3'd0});
    rows.push_back('{1'b0, 8'h01, 1'b0, 1'b1, 3'd0});
    rows.push_back('{1'b1, 8'h03, 1'b0, 1'b0, 3'd0});
    for (int i = 0; i < 4; i++) rows.push_back('{1'b0, 8'h03, 1'b0, 1'b1, 3'd0});
    rows.push_back('{1'b0, 8'h03, 1'b1, 1'b1, 3'd1});
    rows.push_back('{1'b0, 8'h03, 1'b0, 1'b1, 3'd1});
    foreach (rows[k]) begin
      @(negedge clk);
      rst = rows[k].rs; req = rows[k].rq; done = rows[k].dn;
      sb.push_back('{rows[k].v, rows[k].ix});
      @(posedge clk); #1;
      e = sb.pop_front();
      eg = e.v ? (8'b1 << e.ix) : 8'b0;
      checks++;
      if ({gnt_valid, gnt_idx, gnt} !== {e.v, e.ix, eg}) begin
        errors++;
        $display("FAIL timeout[%0d]: got v=%0b idx=%0d gnt=%h, want v=%0b idx=%0d gnt=%h",
                 k, gnt_valid, gnt_idx, gnt, e.v, e.ix, eg);
      end
    end
  endtask

  task automatic test_req_drop();
    row_t rows[$] = '{
      '{1'b1, 8'h00, 1'b0, 1'b0, 3'd0},
      '{1'b0, 8'h20, 1'b0, 1'b1, 3'd5},
      '{1'b0, 8'h40, 1'b0, 1'b1, 3'd6},
      '{1'b0, 8'h41, 1'b0, 1'b1, 3'd6},
      '{1'b0, 8'h01, 1'b0, 1'b1, 3'd0},
      '{1'b0, 8'h00, 1'b0, 1'b0, 3'd0},
      '{1'b0, 8'h20, 1'b0, 1'b1, 3'd5},
      '{1'b0, 8'h00, 1'b0, 1'b0, 3'd0}
    };
    exp_t e;
    logic [7:0] eg;
    foreach (rows[k]) begin
      @(negedge clk);
      rst = rows[k].rs; req = rows[k].rq; done = rows[k].dn;
      sb.push_back('{rows[k].v, rows[k].ix});
      @(posedge clk); #1;
      e = sb.pop_front();
      eg = e.v ? (8'b1 << e.ix) : 8'b0;
      checks++;
      if ({gnt_valid, gnt_idx, gnt} !== {e.v, e.ix, eg}) begin
        errors++;
        $display("FAIL req_drop[%0d]: got v=%0b idx=%0d gnt=%h, want v=%0b idx=%0d gnt=%h",
                 k, gnt_valid, gnt_idx, gnt, e.v, e.ix, eg);
      end
    end
  endtask

  task automatic test_idle_done_and_reset_mid();
    row_t rows[$] = '{
      '{1'b1, 8'h00, 1'b0, 1'b0, 3'd0},
      '{1'b0, 8'h00, 1'b1, 1'b0, 3'd0},
      '{1'b0, 8'h08, 1'b1, 1'b1, 3'd3},
      '{1'b0, 8'h08, 1'b0, 1'b1, 3'd3},
      '{1'b1, 8'h40, 1'b0, 1'b0, 3'd0},
      '{1'b0, 8'h40, 1'b0, 1'b1, 3'd6},
      '{1'b0, 8'h40, 1'b0, 1'b1, 3'd6},
      '{1'b1, 8'h40, 1'b0, 1'b0, 3'd0},
      '{1'b0, 8'h41, 1'b0, 1'b1, 3'd0},
      '{1'b0, 8'h41, 1'b1, 1'b1, 3'd6}
    };
    exp_t e;
    logic [7:0] eg;
    foreach (rows[k]) begin
      @(negedge clk);
      rst = rows[k].rs; req = rows[k].rq; done = rows[k].dn;
      sb.push_back('{rows[k].v, rows[k].ix});
      @(posedge clk); #1;
      e = sb.pop_front();
      eg = e.v ? (8'b1 << e.ix) : 8'b0;
      checks++;
      if ({gnt_valid, gnt_idx, gnt} !== {e.v, e.ix, eg}) begin
        errors++;
        $display("FAIL idle_reset[%0d]: got v=%0b idx=%0d gnt=%h, want v=%0b idx=%0d gnt=%h",
                 k, gnt_valid, gnt_idx, gnt, e.v, e.ix, eg);
      end
    end
  endtask

  initial begin
    test_reset();
    test_rotation();
    test_sparse_wrap();
    test_timeout();
    test_req_drop();
    test_idle_done_and_reset_mid();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d entries left, want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
